// File: rtl/regfile_sb.sv
// Parametrised register file with two async read ports, one write port, a sequential
// clear engine and a per-entry pending scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rdy1,
  output logic              rdy2,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int              DEPTH = 2 ** ADDR_W;
  localparam bit              HW0   = (ZERO_REG == 1);
  localparam logic [ADDR_W-1:0] LAST = '1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pend_next;
  logic [ADDR_W:0]   cnt_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic accept;
  logic wr_ok;
  logic rsv_ok;
  logic inc;
  logic dec;
  logic fwd1;
  logic fwd2;

  // A clear request in IDLE takes priority and swallows any same-cycle write or reservation.
  assign accept = (state == IDLE) && !clr_req;
  assign wr_ok  = accept && we     && !(HW0 && (waddr == '0));
  assign rsv_ok = accept && rsv_en && !(HW0 && (rsv_addr == '0));

  // Reservation beats a same-address write, so the write only releases a bit nobody re-claims.
  assign inc = rsv_ok && !pending[rsv_addr];
  assign dec = wr_ok && pending[waddr] && !(rsv_ok && (rsv_addr == waddr));

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      idx      <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      pending  <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    pend_next  = pending;
    cnt_next   = pend_cnt;
    case (state)
      CLEAR: begin
        idx_next = idx + 1'b1;
        if (idx == LAST) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (clr_req) begin
          state_next = CLEAR;
          idx_next   = '0;
          pend_next  = '0;
          cnt_next   = '0;
        end else begin
          if (wr_ok) begin
            pend_next[waddr] = 1'b0;
          end
          if (rsv_ok) begin
            pend_next[rsv_addr] = 1'b1;
          end
          cnt_next = pend_cnt + (ADDR_W + 1)'(inc) - (ADDR_W + 1)'(dec);
        end
      end
      default: begin
        state_next = CLEAR;
        idx_next   = '0;
      end
    endcase
  end

  // Storage has no reset; the clear engine zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  assign fwd1 = BYPASS && we && (waddr == raddr1) && !(HW0 && (raddr1 == '0));
  assign fwd2 = BYPASS && we && (waddr == raddr2) && !(HW0 && (raddr2 == '0));

  always_comb begin
    rdata1 = '0;
    rdy1   = 1'b0;
    if (state == IDLE) begin
      if (HW0 && (raddr1 == '0)) begin
        rdy1 = 1'b1;
      end else if (fwd1) begin
        rdata1 = wdata;
        rdy1   = 1'b1;
      end else begin
        rdata1 = mem[raddr1];
        rdy1   = !pending[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    rdy2   = 1'b0;
    if (state == IDLE) begin
      if (HW0 && (raddr2 == '0)) begin
        rdy2 = 1'b1;
      end else if (fwd2) begin
        rdata2 = wdata;
        rdy2   = 1'b1;
      end else begin
        rdata2 = mem[raddr2];
        rdy2   = !pending[raddr2];
      end
    end
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the CPU integer register file.
- Generic data width and depth, two asynchronous read ports and one synchronous write port.
- Hardware sequential-clear engine (runs after reset and on demand) replaces the simulation-only initial block.
- Per-register scoreboard (pending bits) lets the issue stage stall on unresolved destinations.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 is hardwired: reads return 0, and writes and reservations to it are dropped

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
clr_req  input  1  start a sequential clear of all entries; honoured in IDLE only
busy  output  1  high while clear is in progress
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
raddr1  input  ADDR_W  read address, port 1
raddr2  input  ADDR_W  read address, port 2
rdata1  output  DATA_W  read data, port 1 (combinational)
rdata2  output  DATA_W  read data, port 2 (combinational)
rdy1  output  1  entry at raddr1 is not pending
rdy2  output  1  entry at raddr2 is not pending
rsv_en  input  1  reserve a destination: set its pending bit
rsv_addr  input  ADDR_W  address to reserve
pend_cnt  output  ADDR_W+1  number of pending bits currently set

Behaviour:
- FSM has two states, CLEAR and IDLE. A clear index idx (ADDR_W bits) is held in a register.
- Reset (rst=0, asynchronous):
  - state=CLEAR, idx=0, all pending bits=0, pend_cnt=0.
  - busy=1; rdata1/rdata2=0; rdy1/rdy2=0.
  - The storage array is not reset directly.
- CLEAR state:
  - Each cycle, entry[idx] <= 0 and idx increments.
  - When idx==DEPTH-1 is written, the next state is IDLE.
  - busy stays high for exactly DEPTH cycles after reset release or after clr_req acceptance.
  - we, rsv_en and clr_req are ignored (dropped, not queued).
  - rdata=0 and rdy=0 on both ports.
- Transition IDLE->CLEAR on clr_req=1:
  - Sets idx=0 and clears all pending bits and pend_cnt on the same edge.
  - we/rsv_en in that same cycle are dropped.
- Write (IDLE, we=1):
  - entry[waddr] <= wdata at the rising edge.
  - pending[waddr] is cleared.
  - If ZERO_REG=1 and waddr==0, the write is a no-op.
- Reserve (IDLE, rsv_en=1):
  - pending[rsv_addr] is set.
  - If ZERO_REG=1 and rsv_addr==0, the reservation is a no-op.
- Simultaneous write and reserve to the same address: the reservation wins, so the bit stays/becomes set (a newer producer is in flight).
- Reserving an already-pending entry: no change.
- Writing a non-pending entry: pending unaffected.
- pend_cnt:
  - Registered counter, net update per cycle: +1 for a set of a clear bit, -1 for a clear of a set bit.
  - Write and reserve to different addresses in the same cycle may give a net change of 0.
  - Must always equal the popcount of the pending bits.
  - Maximum value is DEPTH (or DEPTH-1 when ZERO_REG=1); no wrap.
- Reads (IDLE):
  - rdataN = entry[raddrN]; rdyN = ~pending[raddrN].
  - raddrN==0 with ZERO_REG=1 gives rdata=0, rdy=1.
  - Same-cycle write is visible only after the edge (unless the optional feature is enabled).
- Reset asserted mid-CLEAR or mid-operation:
  - Immediately returns to reset values.
  - Clear restarts from idx=0 after release.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. In IDLE with we=1 and waddrN-match (raddrN==waddr, and not the hardwired zero entry), rdataN=wdata and rdyN=1 combinationally in the same cycle. A same-cycle reservation to that address does not suppress the forwarded data or rdy.
- Undefined: no forwarding. Reads return the stored value and the current pending state; a write becomes visible on the cycle after the edge.

Test Plan:
- Release rst, DEPTH=32 -> busy=1 for exactly 32 cycles then 0; every entry reads 0 with rdy=1; pend_cnt=0.
- IDLE, we=1 waddr=5 wdata=0xDEADBEEF -> after the edge raddr1=5 gives 0xDEADBEEF. With REGFILE_BYPASS_EN, same cycle raddr1=5 gives 0xDEADBEEF; without it, gives 0.
- rsv_en=1 rsv_addr=7 -> rdy for raddr2=7 is 0, pend_cnt=1. Then we=1 waddr=7 wdata=0x12 -> rdy=1, pend_cnt=0, rdata=0x12.
- Same cycle: rsv_en addr 9 and we addr 9 (9 pending) -> pending[9] stays 1, pend_cnt unchanged, data updated. Also: we addr 3 (pending) and rsv addr 4 -> pend_cnt unchanged.
- ZERO_REG=1: we waddr=0 wdata=0xFFFFFFFF and rsv addr 0 -> raddr=0 gives 0, rdy=1, pend_cnt unchanged.
- Entries written and 3 pending; assert clr_req -> busy for 32 cycles, writes during busy dropped, then all entries 0 and pend_cnt=0. Assert rst at cycle 10 of clear -> clear restarts after release and takes a full 32 cycles.
